// File: rtl/image_pkg.sv
`default_nettype none
// =============================================================================
// Module      : image_pkg
// Description : Shared image geometry defaults and loader state encoding.
// Revision    : 1.0
// =============================================================================
package image_pkg;

    localparam int c_DATA_WIDTH  = 8;
    localparam int c_ADDR_WIDTH  = 19;
    localparam int c_FRAME_WORDS = 384000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_DONE = ST_DONE
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/image_ram_loader_if.sv
`default_nettype none
// =============================================================================
// Module      : image_ram_loader_if
// Description : Byte-stream input, RAM write port and status of the loader.
// Revision    : 1.0
// =============================================================================
interface image_ram_loader_if #(
    parameter int DATA_WIDTH = image_pkg::c_DATA_WIDTH,
    parameter int ADDR_WIDTH = image_pkg::c_ADDR_WIDTH
);
    logic                  start;
    logic                  abort;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_d;
    logic                  busy;
    logic                  done;

    modport master (
        output start, abort, s_data, s_valid,
        input  s_ready, ram_we, ram_addr, ram_d, busy, done
    );

    modport slave (
        input  start, abort, s_data, s_valid,
        output s_ready, ram_we, ram_addr, ram_d, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/image_ram_loader_counter.sv
`default_nettype none
// =============================================================================
// Module      : frame_addr_counter
// Description : Frame word counter with clear, enable and last-word flag.
// Revision    : 1.0
// =============================================================================
module frame_addr_counter #(
    parameter int ADDR_WIDTH  = image_pkg::c_ADDR_WIDTH,
    parameter int FRAME_WORDS = image_pkg::c_FRAME_WORDS
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_clr,
    input  wire logic                  i_en,
    output logic      [ADDR_WIDTH-1:0] o_cnt,
    output logic                       o_last
);
    // Compare against the last index so a full 2^ADDR_WIDTH frame never relies on overflow.
    localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(FRAME_WORDS - 1);

    logic [ADDR_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/image_ram_loader.sv
`default_nettype none
// =============================================================================
// Module      : image_ram_loader
// Description : Streams one frame of pixel bytes into the image RAM from address 0.
// Revision    : 1.0
// =============================================================================
module image_ram_loader
    import image_pkg::*;
#(
    parameter int DATA_WIDTH  = c_DATA_WIDTH,
    parameter int ADDR_WIDTH  = c_ADDR_WIDTH,
    parameter int FRAME_WORDS = c_FRAME_WORDS
) (
    input  wire logic     clk,
    input  wire logic     rst,
    image_ram_loader_if.slave bus
);
    loader_state_t         r_state;
    loader_state_t         w_next;
    logic                  w_xfer;
    logic                  w_clr;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_wcnt;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_d;
    logic                  r_done;

    // Abort dominates both a pending transfer and a start request.
    assign w_xfer = (r_state == S_LOAD) && bus.s_valid && !bus.abort;
    assign w_clr  = bus.abort || ((r_state == S_IDLE) && bus.start);

    frame_addr_counter #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_en   (w_xfer),
        .o_cnt  (w_wcnt),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    w_next = S_IDLE;
                end else if (w_xfer && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_d    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_ram_we <= w_xfer;
            r_done   <= (r_state == S_DONE) && !bus.abort;
            if (w_xfer) begin
                r_ram_addr <= w_wcnt;
                r_ram_d    <= bus.s_data;
            end
        end
    end

    assign bus.s_ready  = (r_state == S_LOAD);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.ram_we   = r_ram_we;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_d    = r_ram_d;
    assign bus.done     = r_done;
endmodule
`default_nettype wire

// File: tb/tb_image_ram_loader.sv
`default_nettype none
// =============================================================================
// Module      : tb_image_ram_loader
// Description : Scoreboard bench driving a full-range (8 words, 3-bit address) and a 4-word loader.
// Revision    : 1.0
// =============================================================================
module tb_image_ram_loader;

    typedef struct {
        bit we;
        int addr;
        int data;
        bit done;
        bit busy;
        bit ready;
    } cyc_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk;
    logic rst;

    image_ram_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3))  ia ();
    image_ram_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(19)) ib ();

    image_ram_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FRAME_WORDS(8)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    image_ram_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(19), .FRAME_WORDS(4)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    cyc_t cq [2][$];
    wr_t  wq [2][$];
    bit   dq [2][$];

    bit m_load [2];
    bit m_fin  [2];
    int m_cnt  [2];
    int m_addr [2];
    int m_data [2];
    int exp_img[2][8];
    int mem    [2][8];

    function automatic int fw(int i);
        return (i == 0) ? 8 : 4;
    endfunction

    // Reference behaviour: one call per clock edge, producing what is visible after it.
    task automatic model_step(int i, bit r, bit st, bit ab, bit v, int d);
        cyc_t e;
        wr_t  w;
        bit   we = 1'b0;
        bit   dn = 1'b0;
        if (r) begin
            m_load[i] = 1'b0; m_fin[i] = 1'b0; m_cnt[i] = 0;
            m_addr[i] = 0;    m_data[i] = 0;
        end else if (ab) begin
            m_load[i] = 1'b0; m_fin[i] = 1'b0; m_cnt[i] = 0;
        end else if (m_fin[i]) begin
            m_fin[i] = 1'b0;
            dn = 1'b1;
            dq[i].push_back(1'b1);
        end else if (m_load[i]) begin
            if (v) begin
                we = 1'b1;
                m_addr[i] = m_cnt[i];
                m_data[i] = d;
                exp_img[i][m_cnt[i]] = d;
                w.addr = m_cnt[i];
                w.data = d;
                wq[i].push_back(w);
                m_cnt[i]++;
                if (m_cnt[i] == fw(i)) begin
                    m_load[i] = 1'b0;
                    m_fin[i]  = 1'b1;
                end
            end
        end else if (st) begin
            m_load[i] = 1'b1;
            m_cnt[i]  = 0;
        end
        e.we    = we;
        e.addr  = m_addr[i];
        e.data  = m_data[i];
        e.done  = dn;
        e.busy  = m_load[i] | m_fin[i];
        e.ready = m_load[i];
        cq[i].push_back(e);
    endtask

    task automatic cyc(bit r, bit st, bit ab, bit v, logic [7:0] d);
        rst        = r;
        ia.start   = st; ib.start   = st;
        ia.abort   = ab; ib.abort   = ab;
        ia.s_valid = v;  ib.s_valid = v;
        ia.s_data  = d;  ib.s_data  = d;
        for (int i = 0; i < 2; i++) model_step(i, r, st, ab, v, int'(d));
        @(posedge clk);
        #1;
    endtask

    task automatic fail_line(string name, int i, int act, int req);
        miscompares++;
        $display("FAIL %s dut%0d @%0t: got %0d, want %0d", name, i, $time, act, req);
    endtask

    task automatic check_inst(int i, bit we, int addr, int data, bit done, bit busy, bit ready);
        cyc_t e;
        wr_t  w;
        if (cq[i].size() > 0) begin
            e = cq[i].pop_front();
            vectors++;
            if (we    != e.we)    fail_line("ram_we",   i, int'(we),    int'(e.we));
            if (addr  != e.addr)  fail_line("ram_addr", i, addr,        e.addr);
            if (data  != e.data)  fail_line("ram_d",    i, data,        e.data);
            if (done  != e.done)  fail_line("done",     i, int'(done),  int'(e.done));
            if (busy  != e.busy)  fail_line("busy",     i, int'(busy),  int'(e.busy));
            if (ready != e.ready) fail_line("s_ready",  i, int'(ready), int'(e.ready));
        end
        if (we) begin
            if (wq[i].size() == 0) begin
                fail_line("unexpected_write", i, addr, -1);
            end else begin
                w = wq[i].pop_front();
                if (addr != w.addr) fail_line("write_addr", i, addr, w.addr);
                if (data != w.data) fail_line("write_data", i, data, w.data);
            end
        end
        if (done) begin
            if (dq[i].size() == 0) begin
                fail_line("unexpected_done", i, 1, 0);
            end else begin
                void'(dq[i].pop_front());
                for (int k = 0; k < fw(i); k++) begin
                    if (mem[i][k] != exp_img[i][k]) fail_line("readback", i, mem[i][k], exp_img[i][k]);
                end
            end
        end
    endtask

    // External RAM models, read back when a frame completes.
    always @(posedge clk) begin
        if (ia.ram_we) mem[0][int'(ia.ram_addr)] <= int'(ia.ram_d);
        if (ib.ram_we) mem[1][int'(ib.ram_addr[2:0])] <= int'(ib.ram_d);
    end

    always @(negedge clk) begin
        check_inst(0, ia.ram_we, int'(ia.ram_addr), int'(ia.ram_d), ia.done, ia.busy, ia.s_ready);
        check_inst(1, ib.ram_we, int'(ib.ram_addr), int'(ib.ram_d), ib.done, ib.busy, ib.s_ready);
    end

    logic [7:0] bytes [8];
    logic [7:0] rb;

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) begin
                exp_img[i][k] = 0;
                mem[i][k]     = 0;
            end
        end
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        rst = 1'b1;
        ia.start = 1'b0; ia.abort = 1'b0; ia.s_valid = 1'b0; ia.s_data = '0;
        ib.start = 1'b0; ib.abort = 1'b0; ib.s_valid = 1'b0; ib.s_data = '0;
        #1;

        repeat (3) cyc(1, 0, 0, 0, 8'h00);
        repeat (2) cyc(0, 0, 0, 1, 8'h5A);

        // Byte in the start cycle must be ignored; then a held-valid frame.
        cyc(0, 1, 0, 1, 8'hAA);
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1, bytes[k]);
        repeat (3) cyc(0, 0, 0, 0, 8'h00);

        // start together with abort in IDLE stays idle.
        cyc(0, 1, 1, 1, 8'h99);
        repeat (2) cyc(0, 0, 0, 1, 8'h98);

        // Partial load aborted, then a clean reload with valid toggling.
        cyc(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 8'hC0 + 8'(k));
        cyc(0, 0, 1, 1, 8'hEE);
        cyc(0, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 16; k++) cyc(0, 0, 0, k[0] == 1'b0, 8'hD0 + 8'(k));
        repeat (3) cyc(0, 0, 0, 0, 8'h00);

        // start asserted mid-load is ignored and the byte alongside it is taken normally.
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'hE1);
        cyc(0, 1, 0, 1, 8'hE2);
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1, 8'hE3 + 8'(k));
        repeat (2) cyc(0, 0, 0, 0, 8'h00);

        // Reset mid-load with valid high.
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'hF1);
        cyc(1, 0, 0, 1, 8'hF2);
        repeat (2) cyc(0, 0, 0, 1, 8'hF3);

        for (int n = 0; n < 400; n++) begin
            rb = 8'($urandom_range(0, 255));
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 2) != 0),
                rb);
        end
        repeat (12) cyc(0, 0, 0, 0, 8'h00);

        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (wq[i].size() != 0) fail_line("writes_missing", i, 0, wq[i].size());
            vectors++;
            if (dq[i].size() != 0) fail_line("done_missing", i, 0, dq[i].size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_ram_loader.md
# image_ram_loader

Writes one full image frame into the single-port image RAM from an incoming byte stream. Accepts pixel bytes over a valid/ready handshake and issues sequential, registered write cycles (addr, data, write enable) starting at address 0. It sits between the host byte source (UART/serial receiver) and the RAM that the LCD pixel fetcher reads back through its addr → q port. This makes it the writer counterpart of the existing ROM read path.

## Interface
- DATA_WIDTH, 8: pixel byte width.
- ADDR_WIDTH, 19: RAM address width.
- FRAME_WORDS, 384000: words per frame (800×480). Legal range is 2..2^ADDR_WIDTH.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin loading a frame.
- abort  in  1  cancels the load in progress.
- s_data  in  DATA_WIDTH  incoming pixel byte.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  the loader accepts s_data this cycle.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM write address.
- ram_d  out  DATA_WIDTH  RAM write data.
- busy  out  1  a load is in progress (LOAD or DONE state).
- done  out  1  one-cycle pulse: frame completely written.

## Operation
- States:
  - IDLE: s_ready=0, busy=0.
  - LOAD: s_ready=1, busy=1.
  - DONE: s_ready=0, busy=1.
- IDLE→LOAD on start. The word counter wcnt clears to 0 on that edge.
- In LOAD, a transfer occurs when s_valid & s_ready on an edge. On that edge:
  - ram_d ← s_data
  - ram_addr ← wcnt
  - ram_we ← 1
  - wcnt ← wcnt+1
- In LOAD, a cycle without a transfer writes ram_we ← 0. ram_addr and ram_d hold their previous values.
- LOAD→DONE on the edge that accepts the word at wcnt == FRAME_WORDS-1. That edge also registers the final write.
- DONE→IDLE on the next edge, with done ← 1 for exactly one cycle and ram_we ← 0.
- start while busy is ignored.
- start and abort together in IDLE: abort wins, and the loader stays in IDLE.
- abort in LOAD or DONE: next state is IDLE, ram_we ← 0, no done pulse, wcnt ← 0. RAM contents already written are left as-is.
- abort and a valid transfer in the same cycle: abort wins, and the byte is not accepted or written.
- wcnt is ADDR_WIDTH bits wide. It never wraps, because LOAD exits at FRAME_WORDS-1.
- Behaviour when FRAME_WORDS = 2^ADDR_WIDTH:
  - The final address is all-ones.
  - The terminal compare uses FRAME_WORDS-1, not overflow.

## Timing
- Reset values: state IDLE, wcnt 0, ram_we 0, ram_addr 0, ram_d 0, done 0, busy 0, s_ready 0.
- Reset mid-load behaves like abort and overrides every other input.
- s_ready and busy are decoded from the state register only. They do not combinationally depend on s_valid.
- Latency: a byte accepted at edge k is on the RAM port (ram_we=1) during the cycle after edge k. The RAM captures it at edge k+1.
- Throughput: one byte per clock. A full frame with s_valid held high takes FRAME_WORDS+1 cycles from start to done high.
- First s_ready=1 cycle: the cycle after the start edge. A byte presented during the start cycle is not accepted.

## Structure
- Shared package (image_pkg) holds:
  - the DATA_WIDTH, ADDR_WIDTH and FRAME_WORDS defaults, kept identical to the read-side ROM/RAM,
  - the state encoding localparams ST_IDLE, ST_LOAD, ST_DONE.
- The block is one module plus one natural sub-module: frame_addr_counter (clear, enable, terminal-count flag at FRAME_WORDS-1).
- The RAM itself is external.

## Test plan
- Reset, then start, then 4 bytes 0x11,0x22,0x33,0x44 with FRAME_WORDS=4 and s_valid held → ram_we high for 4 consecutive cycles at addr 0..3 with those data, done high exactly one cycle after the last ram_we, busy low afterwards.
- FRAME_WORDS=8, s_valid toggling every other cycle → 8 writes at addr 0..7, no gaps in addressing, ram_we low in the idle cycles, done after the 8th write.
- Abort after 3 of 8 bytes → no done pulse, state IDLE. A following start plus 8 bytes writes addr 0..7.
- start asserted mid-load, plus s_valid during the start cycle → both ignored. The first write goes to addr 0 with the first byte presented while s_ready=1.
- rst asserted during LOAD with s_valid=1 → all outputs at their reset values on the next cycle, no write.
- ADDR_WIDTH=3, FRAME_WORDS=8 → final write at addr 7, no wrap, done asserted. Readback through the ROM/RAM read port returns the loaded bytes.
